axi_tdd_stream_gate: RTL and testbench

AXI_TDD_STREAM_GATE -- requirements
Module: axi_tdd_stream_gate

---
 rtl/axi_tdd_stream_gate.sv | 143 ++++++++++++++
 tb/tb_axi_tdd_stream_gate.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/axi_tdd_stream_gate.sv
// Gates an AXI-Stream onto TDD channel windows, marking the last beat of each window with tlast.
// A one-beat hold register delays output so the final beat of a window can be tagged when it closes.
module axi_tdd_stream_gate #(
   parameter int DATA_WIDTH   = 64,
   parameter int COUNT_WIDTH  = 32,
   parameter bit DROP_OUTSIDE = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   enable,
   input  logic                   tdd_ch,
   input  logic [COUNT_WIDTH-1:0] max_beats,
   input  logic                   s_axis_tvalid,
   output logic                   s_axis_tready,
   input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
   output logic                   m_axis_tvalid,
   input  logic                   m_axis_tready,
   output logic [DATA_WIDTH-1:0]  m_axis_tdata,
   output logic                   m_axis_tlast,
   output logic [COUNT_WIDTH-1:0] window_count,
   output logic [COUNT_WIDTH-1:0] drop_count,
   output logic                   truncated,
   output logic                   empty_window
);

   typedef enum logic [1:0] {IDLE, OPEN, FLUSH, WAIT_LOW} state_t;

   state_t                 state, state_nxt;
   logic [DATA_WIDTH-1:0]  h_data, o_data;
   logic                   hv, ov, o_last;
   logic [COUNT_WIDTH-1:0] beat_cnt, max_lat, beat_inc;
   logic                   win_on, accept, drop, move, move_last, open_win, trunc_nxt, empty_nxt;

   assign win_on        = enable && tdd_ch;
   assign beat_inc      = beat_cnt + COUNT_WIDTH'(1);
   assign m_axis_tvalid = ov;
   assign m_axis_tdata  = o_data;
   assign m_axis_tlast  = o_last;

   always_comb begin
      state_nxt     = state;
      s_axis_tready = 1'b0;
      accept        = 1'b0;
      drop          = 1'b0;
      move          = 1'b0;
      move_last     = 1'b0;
      open_win      = 1'b0;
      trunc_nxt     = 1'b0;
      empty_nxt     = 1'b0;
      if (!rst) begin
         case (state)
            IDLE: begin
               s_axis_tready = DROP_OUTSIDE;
               drop          = s_axis_tvalid && DROP_OUTSIDE;
               if (win_on) begin
                  state_nxt = OPEN;
                  open_win  = 1'b1;
               end
            end
            OPEN: begin
               // The closing edge is already outside the window, so its beat is treated as such.
               if (!win_on) begin
                  s_axis_tready = DROP_OUTSIDE;
                  drop          = s_axis_tvalid && DROP_OUTSIDE;
                  state_nxt     = FLUSH;
               end else begin
                  s_axis_tready = !hv || !ov || m_axis_tready;
                  accept        = s_axis_tvalid && s_axis_tready;
                  move          = accept && hv;
                  if (accept && (max_lat != '0) && (beat_inc == max_lat)) begin
                     state_nxt = FLUSH;
                     trunc_nxt = 1'b1;
                  end
               end
            end
            FLUSH: begin
               s_axis_tready = DROP_OUTSIDE;
               drop          = s_axis_tvalid && DROP_OUTSIDE;
               if (hv) begin
                  if (!ov || m_axis_tready) begin
                     move      = 1'b1;
                     move_last = 1'b1;
                     state_nxt = win_on ? WAIT_LOW : IDLE;
                  end
               end else begin
                  empty_nxt = (beat_cnt == '0);
                  state_nxt = win_on ? WAIT_LOW : IDLE;
               end
            end
            WAIT_LOW: begin
               s_axis_tready = DROP_OUTSIDE;
               drop          = s_axis_tvalid && DROP_OUTSIDE;
               if (!win_on) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         hv           <= 1'b0;
         ov           <= 1'b0;
         o_last       <= 1'b0;
         beat_cnt     <= '0;
         max_lat      <= '0;
         window_count <= '0;
         drop_count   <= '0;
         truncated    <= 1'b0;
         empty_window <= 1'b0;
      end else begin
         state        <= state_nxt;
         truncated    <= trunc_nxt;
         empty_window <= empty_nxt;
         if (open_win) begin
            window_count <= window_count + COUNT_WIDTH'(1);
            beat_cnt     <= '0;
            max_lat      <= max_beats;
         end
         if (accept) begin
            beat_cnt <= beat_inc;
            hv       <= 1'b1;
         end else if (move) begin
            hv <= 1'b0;
         end
         if (move) begin
            ov     <= 1'b1;
            o_last <= move_last;
         end else if (ov && m_axis_tready) begin
            ov     <= 1'b0;
            o_last <= 1'b0;
         end
         if (drop && (drop_count != '1)) drop_count <= drop_count + COUNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (accept) h_data <= s_axis_tdata;
      if (move)   o_data <= h_data;
   end

endmodule

// File: tb/tb_axi_tdd_stream_gate.sv
// Directed bench for axi_tdd_stream_gate: one instance discards outside windows, one backpressures.
module tb_axi_tdd_stream_gate;
   localparam int DW = 16;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst, enable, tdd_ch, s_valid, m_ready;
   logic [CW-1:0] max_beats;
   logic [DW-1:0] s_data;

   logic          s_ready_a, m_valid_a, m_last_a, trunc_a, empty_a;
   logic [DW-1:0] m_data_a;
   logic [CW-1:0] wc_a, dc_a;
   logic          s_ready_b, m_valid_b, m_last_b, trunc_b, empty_b;
   logic [DW-1:0] m_data_b;
   logic [CW-1:0] wc_b, dc_b;

   always #5 clk = ~clk;

   axi_tdd_stream_gate #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW), .DROP_OUTSIDE(1'b1)) dut_a (
      .clk(clk), .rst(rst), .enable(enable), .tdd_ch(tdd_ch), .max_beats(max_beats),
      .s_axis_tvalid(s_valid), .s_axis_tready(s_ready_a), .s_axis_tdata(s_data),
      .m_axis_tvalid(m_valid_a), .m_axis_tready(m_ready), .m_axis_tdata(m_data_a),
      .m_axis_tlast(m_last_a), .window_count(wc_a), .drop_count(dc_a),
      .truncated(trunc_a), .empty_window(empty_a));

   axi_tdd_stream_gate #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW), .DROP_OUTSIDE(1'b0)) dut_b (
      .clk(clk), .rst(rst), .enable(enable), .tdd_ch(tdd_ch), .max_beats(max_beats),
      .s_axis_tvalid(s_valid), .s_axis_tready(s_ready_b), .s_axis_tdata(s_data),
      .m_axis_tvalid(m_valid_b), .m_axis_tready(m_ready), .m_axis_tdata(m_data_b),
      .m_axis_tlast(m_last_b), .window_count(wc_b), .drop_count(dc_b),
      .truncated(trunc_b), .empty_window(empty_b));

   int passed = 0;
   int total  = 0;

   logic [DW:0]   qa[$];
   logic [DW:0]   qb[$];
   int            trunc_n = 0, empty_n = 0, stall_err = 0;
   logic          chk_stall = 1'b0, prev_stall = 1'b0, prev_last;
   logic [DW-1:0] prev_data;

   // Output beats are captured at the falling edge; the handshake completes on the following rising edge.
   always @(negedge clk) begin
      if (m_valid_a && m_ready) qa.push_back({m_last_a, m_data_a});
      if (m_valid_b && m_ready) qb.push_back({m_last_b, m_data_b});
      if (trunc_a) trunc_n++;
      if (empty_a) empty_n++;
      if (chk_stall && prev_stall &&
          (m_valid_a !== 1'b1 || m_data_a !== prev_data || m_last_a !== prev_last)) stall_err++;
      prev_stall = m_valid_a && !m_ready;
      prev_data  = m_data_a;
      prev_last  = m_last_a;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic check_q(input string tag, input logic [DW:0] q[$], input int n, input int first);
      int errs = 0;
      check({tag, "_beats"}, q.size(), n);
      for (int i = 0; i < q.size() && i < n; i++)
         if (q[i][DW-1:0] !== DW'(first + i) || q[i][DW] !== (i == n - 1)) errs++;
      check({tag, "_order_last"}, errs, 0);
   endtask

   logic src_mode = 1'b0, tog = 1'b0, hs;
   int   sent;

   task tick();
      @(negedge clk);
      hs = s_valid && s_ready_a;
      @(posedge clk);
      #1;
      if (tog) m_ready = !m_ready;
      if (src_mode) begin
         if (hs) begin
            s_data++;
            sent++;
         end
         s_valid = (sent < 6);
      end
   endtask

   initial begin
      rst = 1'b1; enable = 1'b1; tdd_ch = 1'b0; s_valid = 1'b0; s_data = '0;
      m_ready = 1'b1; max_beats = '0; sent = 0;
      tick(); tick();
      check("rst_tvalid", m_valid_a, 0);
      check("rst_tlast", m_last_a, 0);
      check("rst_tready", s_ready_a, 0);
      check("rst_wc", wc_a, 0);
      check("rst_dc", dc_a, 0);
      check("rst_trunc", trunc_a, 0);
      check("rst_empty", empty_a, 0);

      // Outside any window: A discards, B holds off
      rst = 1'b0; s_valid = 1'b1;
      repeat (3) tick();
      check("out_dc_a", dc_a, 3);
      check("out_tready_b", s_ready_b, 0);
      check("out_dc_b", dc_b, 0);

      // Basic 10-cycle window, unlimited beats
      tdd_ch = 1'b1; s_data = 100;
      repeat (10) begin tick(); s_data++; end
      tdd_ch = 1'b0; s_valid = 1'b0;
      repeat (4) tick();
      check_q("basic", qa, 9, 101);
      check("basic_wc", wc_a, 1);
      check("basic_dc", dc_a, 4);
      qa.delete();

      // Truncation at 4 beats in a 20-cycle window
      max_beats = 4; tdd_ch = 1'b1; s_valid = 1'b1; s_data = 200;
      repeat (20) begin tick(); s_data++; end
      tdd_ch = 1'b0; s_valid = 1'b0;
      repeat (4) tick();
      check_q("trunc", qa, 4, 201);
      check("trunc_pulses", trunc_n, 1);
      check("trunc_wc", wc_a, 2);
      check("trunc_dc", dc_a, 20);
      qa.delete();

      // Backpressure: m_axis_tready toggles every cycle, 6-beat source
      max_beats = 0; tdd_ch = 1'b1;
      tick();
      s_data = 301; sent = 0; s_valid = 1'b1; src_mode = 1'b1; tog = 1'b1; chk_stall = 1'b1;
      repeat (19) tick();
      tdd_ch = 1'b0; src_mode = 1'b0; s_valid = 1'b0; tog = 1'b0; m_ready = 1'b1;
      repeat (5) tick();
      chk_stall = 1'b0;
      check_q("bp", qa, 6, 301);
      check("bp_stable", stall_err, 0);
      check("bp_wc", wc_a, 3);
      qa.delete();

      // Empty window
      tdd_ch = 1'b1;
      repeat (5) tick();
      tdd_ch = 1'b0;
      repeat (4) tick();
      check("empty_beats", qa.size(), 0);
      check("empty_pulses", empty_n, 1);
      check("empty_wc", wc_a, 4);

      // Backpressuring instance: enable dropped mid-window flushes the held beat
      qb.delete();
      tdd_ch = 1'b1; s_valid = 1'b1; s_data = 400;
      repeat (4) begin tick(); s_data++; end
      enable = 1'b0;
      repeat (4) tick();
      enable = 1'b1; tdd_ch = 1'b0; s_valid = 1'b0;
      repeat (2) tick();
      check_q("nodrop", qb, 3, 401);
      check("nodrop_dc_b", dc_b, 0);
      qa.delete();

      // Reset with both H and O occupied
      tdd_ch = 1'b1; s_valid = 1'b1; s_data = 500; m_ready = 1'b0;
      repeat (3) begin tick(); s_data++; end
      check("pre_rst_tvalid", m_valid_a, 1);
      rst = 1'b1;
      tick();
      check("midrst_tvalid", m_valid_a, 0);
      check("midrst_tlast", m_last_a, 0);
      check("midrst_tready", s_ready_a, 0);
      check("midrst_wc", wc_a, 0);
      check("midrst_dc", dc_a, 0);
      rst = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
      tick();
      check("post_rst_open_wc", wc_a, 1);
      tdd_ch = 1'b0;
      repeat (4) tick();
      check("post_rst_beats", qa.size(), 0);
      qa.delete();

      // max_beats = 1: single tlast beat per window
      max_beats = 1; tdd_ch = 1'b1; s_valid = 1'b1; s_data = 600;
      repeat (5) begin tick(); s_data++; end
      tdd_ch = 1'b0; s_valid = 1'b0;
      repeat (4) tick();
      check_q("mb1", qa, 1, 601);
      check("mb1_trunc_pulses", trunc_n, 2);
      check("mb1_wc", wc_a, 2);

      // window_count wraps
      max_beats = 0;
      repeat (253) begin
         tdd_ch = 1'b1; tick();
         tdd_ch = 1'b0; tick(); tick();
      end
      check("wc_max", wc_a, 255);
      tdd_ch = 1'b1; tick();
      tdd_ch = 1'b0; tick(); tick();
      check("wc_wrap", wc_a, 0);

      // drop_count saturates
      s_valid = 1'b1;
      repeat (300) tick();
      check("dc_sat", dc_a, 255);
      s_valid = 1'b0;
      tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
